pipeline_hazard_ctrl: RTL and testbench

- Upstream driver of the ID/EX control-vector register's `nop` and `interupt` inputs.
- Detects load-use hazards and taken-branch flushes, and sequences interrupt entry.
- Issues stall, flush and PC-vector commands to the fetch/decode stages so the pipelined RAT never executes a stale or hazarded instruction.

---
 rtl/pipeline_hazard_ctrl.sv | 158 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: drives the ID/EX control-vector register's nop and
// interupt inputs, stalls on load-use hazards, flushes after taken branches and
// sequences interrupt entry (drain EX/WB, inject the push vector, then vector the PC).
module pipeline_hazard_ctrl #(
  parameter int          FLUSH_CYCLES = 2,
  parameter int          DRAIN_CYCLES = 2,
  parameter logic [9:0]  INT_VECTOR   = 10'h3FF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rx_addr,
  input  logic [4:0]  id_ry_addr,
  input  logic        id_uses_rx,
  input  logic        id_uses_ry,
  input  logic [9:0]  id_pc,
  input  logic        ex_rf_wr,
  input  logic [4:0]  ex_wb_addr,
  input  logic        ex_load,
  input  logic        ex_branch_taken,
  input  logic [9:0]  ex_branch_target,
  input  logic        int_req,
  input  logic        i_flag,
  output logic        nop,
  output logic        interupt,
  output logic        pc_stall,
  output logic        ifid_flush,
  output logic        pc_vec_ld,
  output logic [9:0]  pc_vec_addr,
  output logic [9:0]  int_ret_pc,
  output logic        i_clr,
  output logic        int_ack
);

  localparam logic [2:0] FLUSH_LD = 3'(FLUSH_CYCLES - 1);
  localparam logic [2:0] DRAIN_LD = 3'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    INJECT = 2'd2,
    VECTOR = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  flush_cnt, flush_cnt_nxt;
  logic [2:0]  drain_cnt, drain_cnt_nxt;
  logic [9:0]  ret_pc_nxt;
  logic        lu_hz;
  logic        flushing;
  logic        lu_stall;

  // Load-use hazard: EX is loading a register the ID instruction is about to read.
  always_comb begin
    lu_hz = ex_rf_wr & ex_load &
            ((id_uses_rx & (id_rx_addr == ex_wb_addr)) |
             (id_uses_ry & (id_ry_addr == ex_wb_addr)));
  end

  assign flushing    = (flush_cnt != 3'd0);
  assign lu_stall    = (state == IDLE) & ~flushing & ~ex_branch_taken & lu_hz;
  assign pc_vec_addr = INT_VECTOR;

  // Control registers: FSM state, bubble counters and the saved return PC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      flush_cnt  <= 3'd0;
      drain_cnt  <= 3'd0;
      int_ret_pc <= 10'd0;
    end else begin
      state      <= state_nxt;
      flush_cnt  <= flush_cnt_nxt;
      drain_cnt  <= drain_cnt_nxt;
      int_ret_pc <= ret_pc_nxt;
    end
  end

  // Next-state, counter updates and command outputs; reset forces every pulse low.
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    drain_cnt_nxt = drain_cnt;
    ret_pc_nxt    = int_ret_pc;
    nop           = 1'b0;
    interupt      = 1'b0;
    pc_stall      = 1'b0;
    ifid_flush    = 1'b0;
    pc_vec_ld     = 1'b0;
    i_clr         = 1'b0;
    int_ack       = 1'b0;

    // A taken branch restarts the flush window regardless of FSM state.
    if (ex_branch_taken) begin
      flush_cnt_nxt = FLUSH_LD;
    end else if (flushing) begin
      flush_cnt_nxt = flush_cnt - 3'd1;
    end

    unique case (state)
      IDLE: begin
        if (int_req & i_flag & ~ex_branch_taken & ~flushing) begin
          state_nxt     = DRAIN;
          drain_cnt_nxt = DRAIN_LD;
          ret_pc_nxt    = id_pc;
        end
      end
      DRAIN: begin
        nop      = 1'b1;
        pc_stall = 1'b1;
        // A branch resolving while draining redirects the return point and
        // needs a fresh drain window behind it.
        if (ex_branch_taken) begin
          drain_cnt_nxt = DRAIN_LD;
          ret_pc_nxt    = ex_branch_target;
        end else if (drain_cnt == 3'd0) begin
          state_nxt = INJECT;
        end else begin
          drain_cnt_nxt = drain_cnt - 3'd1;
        end
      end
      INJECT: begin
        interupt  = 1'b1;
        pc_stall  = 1'b1;
        state_nxt = VECTOR;
      end
      VECTOR: begin
        pc_vec_ld  = 1'b1;
        i_clr      = 1'b1;
        int_ack    = 1'b1;
        ifid_flush = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (lu_stall) begin
      nop      = 1'b1;
      pc_stall = 1'b1;
    end

    // Branch flush overrides the FSM and load-use: bubble, and clear IF/ID
    // rather than holding it.
    if (ex_branch_taken | flushing) nop = 1'b1;
    if (ex_branch_taken) ifid_flush = 1'b1;
    if (ifid_flush) pc_stall = 1'b0;

    if (!rst_n) begin
      nop        = 1'b0;
      interupt   = 1'b0;
      pc_stall   = 1'b0;
      ifid_flush = 1'b0;
      pc_vec_ld  = 1'b0;
      i_clr      = 1'b0;
      int_ack    = 1'b0;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: the driver pushes hand-computed
// expected outputs for each cycle, a monitor pops and compares at the falling edge.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rx_addr, id_ry_addr, ex_wb_addr;
  logic        id_uses_rx, id_uses_ry, ex_rf_wr, ex_load, ex_branch_taken;
  logic [9:0]  id_pc, ex_branch_target;
  logic        int_req, i_flag;
  logic        nop, interupt, pc_stall, ifid_flush, pc_vec_ld, i_clr, int_ack;
  logic [9:0]  pc_vec_addr, int_ret_pc;

  int checks = 0;
  int errors = 0;

  // Expected vector: {nop, interupt, pc_stall, ifid_flush, pc_vec_ld, i_clr, int_ack, pc_vec_addr, int_ret_pc}
  logic [26:0] exp_q[$];
  string       name_q[$];

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .DRAIN_CYCLES(2), .INT_VECTOR(10'h3FF)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rx_addr(id_rx_addr), .id_ry_addr(id_ry_addr),
    .id_uses_rx(id_uses_rx), .id_uses_ry(id_uses_ry), .id_pc(id_pc),
    .ex_rf_wr(ex_rf_wr), .ex_wb_addr(ex_wb_addr), .ex_load(ex_load),
    .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
    .int_req(int_req), .i_flag(i_flag),
    .nop(nop), .interupt(interupt), .pc_stall(pc_stall), .ifid_flush(ifid_flush),
    .pc_vec_ld(pc_vec_ld), .pc_vec_addr(pc_vec_addr), .int_ret_pc(int_ret_pc),
    .i_clr(i_clr), .int_ack(int_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // Monitor: compare the DUT outputs of this cycle against the queued expectation.
  initial begin
    logic [26:0] act, e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        act = {nop, interupt, pc_stall, ifid_flush, pc_vec_ld, i_clr, int_ack, pc_vec_addr, int_ret_pc};
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s: got nop/int/stall/flush/ld/clr/ack=%b%b%b%b%b%b%b vec=%h ret=%h, want %b vec=%h ret=%h",
                   nm, act[26], act[25], act[24], act[23], act[22], act[21], act[20],
                   act[19:10], act[9:0], e[26:20], e[19:10], e[9:0]);
        end
      end
    end
  end

  // Queue the expectation for the current cycle, then advance one clock.
  task automatic cyc(input string nm, input logic e_nop, input logic e_int,
                     input logic e_stall, input logic e_flush, input logic e_vec,
                     input logic [9:0] e_ret);
    exp_q.push_back({e_nop, e_int, e_stall, e_flush, e_vec, e_vec, e_vec, 10'h3FF, e_ret});
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rx_addr = 5'd0; id_ry_addr = 5'd0; id_uses_rx = 1'b0; id_uses_ry = 1'b0;
    id_pc = 10'd0; ex_rf_wr = 1'b0; ex_wb_addr = 5'd0; ex_load = 1'b0;
    ex_branch_taken = 1'b0; ex_branch_target = 10'd0; int_req = 1'b0; i_flag = 1'b0;
  endtask

  // Stimulus
  initial begin
    clear_inputs();
    rst_n = 1'b0;
    @(posedge clk); #1;
    // Reset with a hazard present: all pulses held low.
    ex_load = 1'b1; ex_rf_wr = 1'b1; ex_wb_addr = 5'd5; id_uses_ry = 1'b1; id_ry_addr = 5'd5;
    cyc("reset_hz", 0, 0, 0, 0, 0, 10'h000);
    clear_inputs();
    cyc("reset", 0, 0, 0, 0, 0, 10'h000);
    rst_n = 1'b1;
    cyc("idle", 0, 0, 0, 0, 0, 10'h000);

    // Load-use hazards
    ex_load = 1'b1; ex_rf_wr = 1'b1; ex_wb_addr = 5'd5; id_uses_ry = 1'b1; id_ry_addr = 5'd5;
    cyc("lu_ry", 1, 0, 1, 0, 0, 10'h000);
    id_uses_ry = 1'b0;
    cyc("lu_ry_unused", 0, 0, 0, 0, 0, 10'h000);
    id_uses_rx = 1'b1; id_rx_addr = 5'd5;
    cyc("lu_rx", 1, 0, 1, 0, 0, 10'h000);
    id_rx_addr = 5'd6;
    cyc("lu_rx_diff", 0, 0, 0, 0, 0, 10'h000);
    id_rx_addr = 5'd5; ex_load = 1'b0;
    cyc("lu_noload", 0, 0, 0, 0, 0, 10'h000);
    ex_load = 1'b1; ex_rf_wr = 1'b0;
    cyc("lu_nowr", 0, 0, 0, 0, 0, 10'h000);

    // Branch flush with a load-use hazard held: flush wins, no stall.
    ex_rf_wr = 1'b1; ex_branch_taken = 1'b1; ex_branch_target = 10'h200;
    cyc("br_T", 1, 0, 0, 1, 0, 10'h000);
    ex_branch_taken = 1'b0;
    cyc("br_T1", 1, 0, 0, 0, 0, 10'h000);
    clear_inputs();
    cyc("br_T2", 0, 0, 0, 0, 0, 10'h000);

    // Back-to-back branches reload the flush window.
    ex_branch_taken = 1'b1;
    cyc("br2_T", 1, 0, 0, 1, 0, 10'h000);
    cyc("br2_T1", 1, 0, 0, 1, 0, 10'h000);
    ex_branch_taken = 1'b0;
    cyc("br2_T2", 1, 0, 0, 0, 0, 10'h000);
    cyc("br2_T3", 0, 0, 0, 0, 0, 10'h000);

    // Interrupt entry; request dropped after DRAIN entry does not abort.
    int_req = 1'b1; i_flag = 1'b1; id_pc = 10'h040;
    cyc("int_T", 0, 0, 0, 0, 0, 10'h000);
    int_req = 1'b0; id_pc = 10'h041;
    cyc("int_drain1", 1, 0, 1, 0, 0, 10'h040);
    cyc("int_drain2", 1, 0, 1, 0, 0, 10'h040);
    cyc("int_inject", 0, 1, 1, 0, 0, 10'h040);
    cyc("int_vector", 0, 0, 0, 1, 1, 10'h040);
    cyc("int_done", 0, 0, 0, 0, 0, 10'h040);

    // Branch in the first DRAIN cycle restarts the drain and redirects the return PC.
    int_req = 1'b1; id_pc = 10'h080;
    cyc("bd_T", 0, 0, 0, 0, 0, 10'h040);
    int_req = 1'b0; ex_branch_taken = 1'b1; ex_branch_target = 10'h120;
    cyc("bd_drain_br", 1, 0, 0, 1, 0, 10'h080);
    ex_branch_taken = 1'b0;
    cyc("bd_drain2", 1, 0, 1, 0, 0, 10'h120);
    cyc("bd_drain3", 1, 0, 1, 0, 0, 10'h120);
    cyc("bd_inject", 0, 1, 1, 0, 0, 10'h120);
    cyc("bd_vector", 0, 0, 0, 1, 1, 10'h120);
    cyc("bd_done", 0, 0, 0, 0, 0, 10'h120);

    // Masked interrupt requests are ignored.
    int_req = 1'b1; i_flag = 1'b0; id_pc = 10'h155;
    for (int i = 0; i < 10; i++) cyc("masked", 0, 0, 0, 0, 0, 10'h120);

    // Reset asserted in the INJECT cycle aborts the sequence.
    i_flag = 1'b1; id_pc = 10'h0AA;
    cyc("ri_T", 0, 0, 0, 0, 0, 10'h120);
    int_req = 1'b0;
    cyc("ri_drain1", 1, 0, 1, 0, 0, 10'h0AA);
    cyc("ri_drain2", 1, 0, 1, 0, 0, 10'h0AA);
    rst_n = 1'b0;
    cyc("ri_rst_inject", 0, 0, 0, 0, 0, 10'h0AA);
    rst_n = 1'b1;
    cyc("ri_after1", 0, 0, 0, 0, 0, 10'h000);
    cyc("ri_after2", 0, 0, 0, 0, 0, 10'h000);

    // Held request re-enters only after returning to IDLE.
    int_req = 1'b1; id_pc = 10'h0C0;
    cyc("re_T", 0, 0, 0, 0, 0, 10'h000);
    cyc("re_drain1", 1, 0, 1, 0, 0, 10'h0C0);
    cyc("re_drain2", 1, 0, 1, 0, 0, 10'h0C0);
    cyc("re_inject", 0, 1, 1, 0, 0, 10'h0C0);
    id_pc = 10'h0C4;
    cyc("re_vector", 0, 0, 0, 1, 1, 10'h0C0);
    cyc("re_idle", 0, 0, 0, 0, 0, 10'h0C0);
    int_req = 1'b0;
    cyc("re_drain_again", 1, 0, 1, 0, 0, 10'h0C4);

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
